// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - T-state ring counter and opcode decoder for the 8-bit accumulator CPU
//
// Purpose: steps a one-hot ring counter through the T-states of each machine
// cycle and decodes the IR opcode into the datapath control word. HLT freezes
// the counter at T4 until reset.
//
// Optional feature macro: CTRL_SEQ_VAR_CYCLE_EN
//   defined   - variable-length machine cycle (OUT/NOP end after T4, LDA after T5)
//   undefined - every instruction runs all six T-states
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   opcode   in   IR upper nibble, valid from T4 onward
//   t_state  out  one-hot ring counter, bit 0 = T1 ... bit 5 = T6
//   cp, ep, lm_n, ce_n, li_n, ei_n, ia, ea, lb_n, su, eu, lo_n
//            out  control word (_n and ia are active-low)
//   halt     out  processor halted

module ctrl_seq #(
    parameter int NCYC = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      opcode,
    output logic [NCYC-1:0] t_state,
    output logic            cp,
    output logic            ep,
    output logic            lm_n,
    output logic            ce_n,
    output logic            li_n,
    output logic            ei_n,
    output logic            ia,
    output logic            ea,
    output logic            lb_n,
    output logic            su,
    output logic            eu,
    output logic            lo_n,
    output logic            halt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [NCYC-1:0] T1 = NCYC'(1) << 0;
    localparam logic [NCYC-1:0] T2 = NCYC'(1) << 1;
    localparam logic [NCYC-1:0] T3 = NCYC'(1) << 2;
    localparam logic [NCYC-1:0] T4 = NCYC'(1) << 3;
    localparam logic [NCYC-1:0] T5 = NCYC'(1) << 4;
    localparam logic [NCYC-1:0] T6 = NCYC'(1) << 5;

    logic [NCYC-1:0] r_t_state;
    logic            r_halt;
    logic [NCYC-1:0] w_t_next;
    logic            w_halt_next;
    logic [NCYC-1:0] w_last_state;
    logic            w_onehot;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_state <= T1;
            r_halt    <= 1'b0;
        end else begin
            r_t_state <= w_t_next;
            r_halt    <= w_halt_next;
        end
    end

    // Final T-state of the current instruction; only consulted in T4..T6,
    // which is exactly when opcode is valid.
    always_comb begin
        w_last_state = T6;
`ifdef CTRL_SEQ_VAR_CYCLE_EN
        case (opcode)
            OP_LDA:         w_last_state = T5;
            OP_ADD, OP_SUB: w_last_state = T6;
            OP_HLT:         w_last_state = T6;
            default:        w_last_state = T4;
        endcase
`endif
    end

    assign w_onehot = (r_t_state != '0) && ((r_t_state & (r_t_state - NCYC'(1))) == '0);

    // Next-state logic
    always_comb begin
        w_t_next    = T1;
        w_halt_next = r_halt;
        if (!w_onehot) begin
            // Corrupted ring recovers to the start of a machine cycle.
            w_t_next = T1;
        end else if (r_halt) begin
            w_t_next = r_t_state;
        end else if (r_t_state == T4 && opcode == OP_HLT) begin
            w_t_next    = T4;
            w_halt_next = 1'b1;
        end else if ((r_t_state & w_last_state) != '0) begin
            w_t_next = T1;
        end else begin
            w_t_next = {r_t_state[NCYC-2:0], 1'b0};
        end
    end

    // Output decode
    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        lm_n = 1'b1;
        ce_n = 1'b1;
        li_n = 1'b1;
        ei_n = 1'b1;
        ia   = 1'b1;
        ea   = 1'b0;
        lb_n = 1'b1;
        su   = 1'b0;
        eu   = 1'b0;
        lo_n = 1'b1;
        if (!r_halt) begin
            case (r_t_state)
                T1: begin
                    ep   = 1'b1;
                    lm_n = 1'b0;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce_n = 1'b0;
                    li_n = 1'b0;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        ei_n = 1'b0;
                        lm_n = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        ea   = 1'b1;
                        lo_n = 1'b0;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ce_n = 1'b0;
                        ia   = 1'b0;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ce_n = 1'b0;
                        lb_n = 1'b0;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eu = 1'b1;
                        ia = 1'b0;
                    end
                end
                default: ;
            endcase
            // Subtract select is held from T4 so the ALU result is settled by T6.
            if (opcode == OP_SUB && (r_t_state == T4 || r_t_state == T5 || r_t_state == T6)) begin
                su = 1'b1;
            end
        end
    end

    assign t_state = r_t_state;
    assign halt    = r_halt;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - scoreboard testbench for ctrl_seq

module tb_ctrl_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       cp, ep, lm_n, ce_n, li_n, ei_n, ia, ea, lb_n, su, eu, lo_n, halt;

    ctrl_seq #(.NCYC(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .t_state (t_state),
        .cp      (cp),
        .ep      (ep),
        .lm_n    (lm_n),
        .ce_n    (ce_n),
        .li_n    (li_n),
        .ei_n    (ei_n),
        .ia      (ia),
        .ea      (ea),
        .lb_n    (lb_n),
        .su      (su),
        .eu      (eu),
        .lo_n    (lo_n),
        .halt    (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ts;
        logic [12:0] word;
        int          step;
        logic [3:0]  op;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] plan[$];
    int         total = 0;
    int         bad   = 0;
    int         m_k;
    bit         m_halt;
    int         policy;

    // Word order: {cp,ep,lm_n,ce_n,li_n,ei_n,ia,ea,lb_n,su,eu,lo_n,halt}
    function automatic logic [12:0] exp_word(int k, logic [3:0] op, bit h);
        logic c_cp = 0, c_ep = 0, c_lm = 1, c_ce = 1, c_li = 1, c_ei = 1, c_ia = 1;
        logic c_ea = 0, c_lb = 1, c_su = 0, c_eu = 0, c_lo = 1;
        bit is_lda = (op == 4'h0);
        bit is_alu = (op == 4'h1) || (op == 4'h2);
        if (h) return {12'b0011_1110_1001, 1'b1};
        if (k == 1) begin c_ep = 1; c_lm = 0; end
        if (k == 2) c_cp = 1;
        if (k == 3) begin c_ce = 0; c_li = 0; end
        if (k == 4 && (is_lda || is_alu)) begin c_ei = 0; c_lm = 0; end
        if (k == 4 && op == 4'hE) begin c_ea = 1; c_lo = 0; end
        if (k == 5 && is_lda) begin c_ce = 0; c_ia = 0; end
        if (k == 5 && is_alu) begin c_ce = 0; c_lb = 0; end
        if (k == 6 && is_alu) begin c_eu = 1; c_ia = 0; end
        if (k >= 4 && op == 4'h2) c_su = 1;
        return {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_ia, c_ea, c_lb, c_su, c_eu, c_lo, 1'b0};
    endfunction

    function automatic int last_step(logic [3:0] op);
`ifdef CTRL_SEQ_VAR_CYCLE_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2 || op == 4'hF) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    function automatic logic [3:0] next_op();
        int r;
        if (plan.size() > 0) return plan.pop_front();
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return 4'h0;
            2, 3:    return 4'h1;
            4, 5:    return 4'h2;
            6:       return 4'hE;
            7:       return 4'hF;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // One clock: advance the model across the edge, then drive the next inputs
    // and queue the response expected before the following edge.
    task automatic step();
        bit   r;
        exp_t e;
        @(posedge clk);
        if (!rst_n) begin
            m_k = 1; m_halt = 0;
        end else if (m_halt) begin
        end else if (m_k == 4 && opcode == 4'hF) begin
            m_halt = 1;
        end else if (m_k >= last_step(opcode)) begin
            m_k = 1;
        end else begin
            m_k = m_k + 1;
        end
        #1;
        case (policy)
            0:       r = 1;
            1:       r = 0;
            2:       r = !(m_k == 5 && !m_halt);
            default: r = !(($urandom_range(0, 63) == 0) || (m_halt && $urandom_range(0, 5) == 0));
        endcase
        rst_n = r;
        if (!r) begin m_k = 1; m_halt = 0; end
        if (m_k == 3 && !m_halt) opcode = next_op();
        e.ts   = 6'(1) << (m_k - 1);
        e.word = exp_word(m_k, opcode, m_halt);
        e.step = m_k;
        e.op   = opcode;
        exp_q.push_back(e);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (t_state !== e.ts) begin
                    bad++;
                    $display("FAIL t_state T%0d op=%h: got %b want %b", e.step, e.op, t_state, e.ts);
                end
                total++;
                if ({cp, ep, lm_n, ce_n, li_n, ei_n, ia, ea, lb_n, su, eu, lo_n, halt} !== e.word) begin
                    bad++;
                    $display("FAIL ctrl_word T%0d op=%h: got %b want %b", e.step, e.op,
                             {cp, ep, lm_n, ce_n, li_n, ei_n, ia, ea, lb_n, su, eu, lo_n, halt}, e.word);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        opcode = 4'h0;
        m_k    = 1;
        m_halt = 0;
        policy = 1;
        repeat (3) step();

        // ADD interrupted by reset in the middle of T5.
        plan.push_back(4'h1);
        policy = 2;
        step();
        n = 0;
        while (rst_n && n < 30) begin step(); n++; end
        total++;
        if (rst_n) begin
            bad++;
            $display("FAIL mid_t5_reset: got no reset want reset in T5");
        end
        policy = 1;
        step();
        policy = 0;

        // Directed instruction sequence ending in HLT.
        plan.push_back(4'h0);
        plan.push_back(4'h2);
        plan.push_back(4'hE);
        plan.push_back(4'h7);
        plan.push_back(4'h1);
        plan.push_back(4'hF);
        n = 0;
        while (!m_halt && n < 100) begin step(); n++; end
        total++;
        if (!m_halt) begin
            bad++;
            $display("FAIL reach_halt: got running want halted");
        end
        repeat (20) step();
        policy = 1;
        step();
        policy = 0;
        repeat (12) step();

        // Random opcodes with occasional asynchronous resets.
        policy = 3;
        repeat (1500) step();

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
